// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock detection, loss-of-lock and saturating error count.
// Define PRBS_CHK_BITCNT_EN to add the bit_cnt output (locked-cycle counter for BER).
module prbs_checker #(
   parameter int POLY_LENGTH = 9,
   parameter int POLY_TAP    = 5,
   parameter int INV_PATTERN = 1,
   parameter int LOCK_COUNT  = 32,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serial_in,
   input  logic                 clear_cnt,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [CNT_WIDTH-1:0] err_cnt,
`ifdef PRBS_CHK_BITCNT_EN
   output logic [31:0]          bit_cnt,
`endif
   output logic                 state_dbg
);

   localparam int FW = $clog2(POLY_LENGTH + 1);
   localparam int EW = $clog2(LOSS_THRESH + 1);
   localparam logic [FW-1:0] FILL_MAX  = FW'(POLY_LENGTH);
   localparam logic [7:0]    LOCK_MAX  = 8'(LOCK_COUNT);
   localparam logic [15:0]   WIN_LAST  = 16'(WINDOW - 1);
   localparam logic [EW:0]   THRESH    = (EW + 1)'(LOSS_THRESH);
   localparam logic          INV_BIT   = 1'(INV_PATTERN);

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   state_t                 state, state_nxt;
   logic [POLY_LENGTH-1:0] sr, sr_nxt;
   logic [FW-1:0]          fill, fill_nxt;
   logic [7:0]             match, match_nxt;
   logic [15:0]            win, win_nxt;
   logic [EW-1:0]          werr, werr_nxt;
   logic                   pulse_nxt;
   logic [CNT_WIDTH-1:0]   cnt_nxt;

   logic       b, p, mis, cmp_valid;
   logic [EW:0] werr_sum;

   assign b         = serial_in ^ INV_BIT;
   assign p         = sr[POLY_LENGTH-1] ^ sr[POLY_TAP-1];
   assign mis       = b ^ p;
   // An all-zero register never validates a compare, so a stuck line cannot lock.
   assign cmp_valid = (fill == FILL_MAX) && (sr != '0);
   assign werr_sum  = {1'b0, werr} + {{EW{1'b0}}, mis};
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      fill_nxt  = fill;
      match_nxt = match;
      win_nxt   = win;
      werr_nxt  = werr;
      pulse_nxt = 1'b0;
      cnt_nxt   = err_cnt;
      case (state)
         SEARCH: begin
            sr_nxt   = {sr[POLY_LENGTH-2:0], b};
            win_nxt  = '0;
            werr_nxt = '0;
            if (fill != FILL_MAX) fill_nxt = fill + 1'b1;
            if (cmp_valid && !mis) begin
               match_nxt = match + 8'd1;
               if (match_nxt == LOCK_MAX) begin
                  state_nxt = LOCKED;
                  match_nxt = '0;
               end
            end else begin
               match_nxt = '0;
            end
         end
         LOCKED: begin
            // Free-running LFSR: a channel error never corrupts the predictor.
            sr_nxt    = {sr[POLY_LENGTH-2:0], p};
            pulse_nxt = mis;
            if (mis && (err_cnt != '1)) cnt_nxt = err_cnt + 1'b1;
            if (werr_sum >= THRESH) begin
               state_nxt = SEARCH;
               fill_nxt  = '0;
               match_nxt = '0;
               win_nxt   = '0;
               werr_nxt  = '0;
            end else if (win == WIN_LAST) begin
               win_nxt  = '0;
               werr_nxt = '0;
            end else begin
               win_nxt  = win + 16'd1;
               werr_nxt = werr_sum[EW-1:0];
            end
         end
         default: state_nxt = SEARCH;
      endcase
      if (clear_cnt) cnt_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         sr        <= '0;
         fill      <= '0;
         match     <= '0;
         win       <= '0;
         werr      <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         sr        <= sr_nxt;
         fill      <= fill_nxt;
         match     <= match_nxt;
         win       <= win_nxt;
         werr      <= werr_nxt;
         locked    <= (state_nxt == LOCKED);
         err_pulse <= pulse_nxt;
         err_cnt   <= cnt_nxt;
      end
   end

`ifdef PRBS_CHK_BITCNT_EN
   always_ff @(posedge clk) begin
      if (rst || clear_cnt) begin
         bit_cnt <= '0;
      end else if (locked && (bit_cnt != 32'hFFFF_FFFF)) begin
         bit_cnt <= bit_cnt + 32'd1;
      end
   end
`endif

endmodule
